// File: rtl/ys_poly_small_exe_p_if.sv
// rtl/ys_poly_small_exe_p_if.sv - control and RAM port bundle for the polynomial coefficient engine
interface ys_poly_small_exe_p_if #(
  parameter int COEF_W = 13,
  parameter int LANES  = 2,
  parameter int N      = 701
);
  localparam int DW = LANES * COEF_W;
  localparam int NW = (N + LANES - 1) / LANES;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;

  logic          start;
  logic [1:0]    mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram1_addr;
  logic [DW-1:0] ram1_dout;
  logic [AW-1:0] ram2_addr;
  logic          ram2_we;
  logic [DW-1:0] ram2_din;

  modport master (
    output start, mode, ram1_dout,
    input  busy, done, ram1_addr, ram2_addr, ram2_we, ram2_din
  );

  modport slave (
    input  start, mode, ram1_dout,
    output busy, done, ram1_addr, ram2_addr, ram2_we, ram2_din
  );
endinterface

// File: rtl/ys_poly_small_exe_p.sv
// rtl/ys_poly_small_exe_p.sv - streams a packed polynomial from ram1 to ram2 applying a per-coefficient update
module ys_poly_small_exe_p #(
  parameter int COEF_W = 13,
  parameter int LANES  = 2,
  parameter int N      = 701,
  parameter int RD_LAT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  ys_poly_small_exe_p_if.slave bus
);
  localparam int DW = LANES * COEF_W;
  localparam int NW = (N + LANES - 1) / LANES;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        mode_q, mode_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [COEF_W-1:0] carry_q, carry_d;
  logic [RD_LAT-1:0] pvld_q, pvld_d;
  logic [AW-1:0]     paddr_q [RD_LAT];
  logic [AW-1:0]     paddr_d [RD_LAT];
  logic              we_q, we_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [DW-1:0]     din_q, din_d;

  // lane k sees c[j-1] at slice k and c[j] at slice k+1; slice 0 is the carry
  logic [DW+COEF_W-1:0] ext;
  assign ext = {bus.ram1_dout, carry_q};

  function automatic logic [COEF_W-1:0] times3(input logic [COEF_W-1:0] x);
    return (x << 1) + x;
  endfunction

  function automatic logic [COEF_W-1:0] lane_op(input logic [1:0] m,
                                                input logic [COEF_W-1:0] prev,
                                                input logic [COEF_W-1:0] cur);
    logic [COEF_W-1:0] diff;
    diff = prev - cur;
    case (m)
      2'd0:    lane_op = times3(cur);
      2'd1:    lane_op = diff;
      2'd2:    lane_op = times3(diff);
      default: lane_op = cur;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mode_d   = mode_q;
    rd_cnt_d = rd_cnt_q;
    carry_d  = carry_q;
    if (pvld_q[RD_LAT-1]) begin
      carry_d = bus.ram1_dout[(LANES-1)*COEF_W +: COEF_W];
    end
    case (state_q)
      S_IDLE: begin
        // the done cycle is still IDLE, so done_q blocks a back-to-back start
        if (bus.start && !done_q) begin
          state_d  = S_READ;
          mode_d   = bus.mode;
          rd_cnt_d = '0;
          carry_d  = '0;
          busy_d   = 1'b1;
        end
      end
      S_READ: begin
        if (rd_cnt_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (we_q && (waddr_q == LAST_ADDR)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pvld_d[0]  = (state_q == S_READ);
    paddr_d[0] = rd_cnt_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pvld_d[i]  = pvld_q[i-1];
      paddr_d[i] = paddr_q[i-1];
    end
  end

  always_comb begin
    we_d    = pvld_q[RD_LAT-1];
    waddr_d = paddr_q[RD_LAT-1];
    din_d   = '0;
    for (int k = 0; k < LANES; k++) begin
      // padding lanes past the polynomial end are forced to zero
      if (int'(paddr_q[RD_LAT-1]) * LANES + k < N) begin
        din_d[k*COEF_W +: COEF_W] = lane_op(mode_q, ext[k*COEF_W +: COEF_W],
                                            ext[(k+1)*COEF_W +: COEF_W]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= '0;
      rd_cnt_q <= '0;
      carry_q  <= '0;
      pvld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) paddr_q[i] <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      din_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      rd_cnt_q <= rd_cnt_d;
      carry_q  <= carry_d;
      pvld_q   <= pvld_d;
      for (int i = 0; i < RD_LAT; i++) paddr_q[i] <= paddr_d[i];
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ram1_addr = rd_cnt_q;
  assign bus.ram2_we   = we_q;
  assign bus.ram2_addr = waddr_q;
  assign bus.ram2_din  = din_q;
endmodule

// File: tb/tb_ys_poly_small_exe_p.sv
// tb/tb_ys_poly_small_exe_p.sv - directed and reference-model bench for ys_poly_small_exe_p
module tb_ys_poly_small_exe_p;
  localparam int W   = 13;
  localparam int L   = 2;
  localparam int NA  = 5;
  localparam int LA  = 1;
  localparam int NWA = 3;
  localparam int NB  = 701;
  localparam int LB  = 3;
  localparam int NWB = 351;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ys_poly_small_exe_p_if #(.COEF_W(W), .LANES(L), .N(NA)) a_if ();
  ys_poly_small_exe_p_if #(.COEF_W(W), .LANES(L), .N(NB)) b_if ();

  ys_poly_small_exe_p #(.COEF_W(W), .LANES(L), .N(NA), .RD_LAT(LA)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );
  ys_poly_small_exe_p #(.COEF_W(W), .LANES(L), .N(NB), .RD_LAT(LB)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  logic [25:0] mem_a [0:3];
  logic [25:0] mem_b [0:511];
  logic [25:0] ra_d1, rb_d1, rb_d2, rb_d3;

  always @(posedge clk) begin
    ra_d1 <= mem_a[a_if.ram1_addr];
    rb_d1 <= mem_b[b_if.ram1_addr];
    rb_d2 <= rb_d1;
    rb_d3 <= rb_d2;
  end
  assign a_if.ram1_dout = ra_d1;
  assign b_if.ram1_dout = rb_d3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int c  [0:703];
  int eo [0:703];
  int base = 0;
  int cap_addr[$];
  int cap_cyc[$];
  logic [25:0] cap_din[$];
  int done_cyc[$];
  logic done_busy[$];

  always @(negedge clk) begin
    if (a_if.ram2_we) begin
      cap_addr.push_back(int'(a_if.ram2_addr));
      cap_din.push_back(a_if.ram2_din);
      cap_cyc.push_back(cyc - base);
    end
    if (b_if.ram2_we) begin
      cap_addr.push_back(int'(b_if.ram2_addr));
      cap_din.push_back(b_if.ram2_din);
      cap_cyc.push_back(cyc - base);
    end
    if (a_if.done) begin
      done_cyc.push_back(cyc - base);
      done_busy.push_back(a_if.busy);
    end
    if (b_if.done) begin
      done_cyc.push_back(cyc - base);
      done_busy.push_back(b_if.busy);
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] exp_word(input int w);
    logic [12:0] lo, hi;
    lo = eo[2*w][12:0];
    hi = eo[2*w+1][12:0];
    return {hi, lo};
  endfunction

  task automatic clear_cap();
    cap_addr.delete();
    cap_cyc.delete();
    cap_din.delete();
    done_cyc.delete();
    done_busy.delete();
  endtask

  task automatic drive(input int sel, input logic s, input logic [1:0] m);
    if (sel == 0) begin
      a_if.start = s;
      a_if.mode  = m;
    end else begin
      b_if.start = s;
      b_if.mode  = m;
    end
  endtask

  // word 2 lane 1 holds junk so pad zeroing and carry clearing are both exercised
  task automatic set_vec(input int v[5], input int o[5]);
    for (int j = 0; j < 6; j++) begin
      if (j < 5) begin
        c[j]  = v[j];
        eo[j] = o[j];
      end else begin
        c[j]  = 1234;
        eo[j] = 0;
      end
    end
    for (int w = 0; w < NWA; w++) mem_a[w] = {c[2*w+1][12:0], c[2*w][12:0]};
  endtask

  task automatic run(input int sel, input logic [1:0] m, input int nw, input int lat, input bit extra);
    logic bsy;
    clear_cap();
    @(negedge clk);
    base = cyc;
    drive(sel, 1'b1, m);
    for (int t = 1; t <= nw + lat + 12; t++) begin
      @(negedge clk);
      drive(sel, extra && (t == 2 || t == 6), extra ? ~m : m);
      bsy = (sel == 0) ? a_if.busy : b_if.busy;
      if (t == 1) chk("busy_in_run", bsy, 1);
    end
    bsy = (sel == 0) ? a_if.busy : b_if.busy;
    chk("busy_after", bsy, 0);
    chk("n_writes", cap_addr.size(), nw);
    for (int i = 0; i < nw && i < cap_addr.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), cap_addr[i], i);
      chk($sformatf("wr_cyc[%0d]", i), cap_cyc[i], lat + 2 + i);
      chk($sformatf("wr_data[%0d]", i), cap_din[i], exp_word(i));
    end
    chk("n_done", done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk("done_cyc", done_cyc[0], nw + lat + 2);
      chk("busy_at_done", done_busy[0], 0);
    end
  endtask

  initial begin
    int p;
    drive(0, 1'b0, 2'd0);
    drive(1, 1'b0, 2'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_we", a_if.ram2_we, 0);
    chk("rst_ram1_addr", a_if.ram1_addr, 0);
    chk("rst_ram2_addr", a_if.ram2_addr, 0);
    chk("rst_ram2_din", a_if.ram2_din, 0);
    rst_n = 1'b1;

    set_vec('{1, 2, 3, 4, 5}, '{8189, 8189, 8189, 8189, 8189});
    run(0, 2'd2, NWA, LA, 1'b0);
    set_vec('{10, 4, 0, 8191, 7}, '{8182, 6, 4, 1, 8184});
    run(0, 2'd1, NWA, LA, 1'b0);
    set_vec('{0, 1, 8191, 2731, 5}, '{0, 3, 8189, 1, 15});
    run(0, 2'd0, NWA, LA, 1'b0);
    set_vec('{0, 1, 8191, 2731, 5}, '{0, 1, 8191, 2731, 5});
    run(0, 2'd3, NWA, LA, 1'b0);
    set_vec('{1, 2, 3, 4, 5}, '{8189, 8189, 8189, 8189, 8189});
    run(0, 2'd2, NWA, LA, 1'b1);

    // reset lands mid-run while writes are in flight
    set_vec('{10, 4, 0, 8191, 7}, '{8182, 6, 4, 1, 8184});
    clear_cap();
    @(negedge clk);
    base = cyc;
    drive(0, 1'b1, 2'd1);
    @(negedge clk);
    drive(0, 1'b0, 2'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", a_if.ram2_we, 0);
    chk("midrst_busy", a_if.busy, 0);
    clear_cap();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_writes", cap_addr.size(), 0);
    run(0, 2'd1, NWA, LA, 1'b0);

    for (int j = 0; j < NB; j++) c[j] = int'($urandom_range(0, 8191));
    c[NB] = int'($urandom_range(1, 8191));
    for (int j = 0; j < NB + 2; j++) begin
      p = (j == 0) ? 0 : c[j-1];
      eo[j] = (j < NB) ? ((3 * (p - c[j])) & 8191) : 0;
    end
    for (int w = 0; w < NWB; w++) mem_b[w] = {c[2*w+1][12:0], c[2*w][12:0]};
    run(1, 2'd2, NWB, LB, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
